// File: rtl/pinwheel_mem_pkg.sv
// Shared types and constants for the pinwheel 2048-byte data RAM and its load/store unit.
package pinwheel_mem_pkg;

    localparam int RAM_BYTES = 2048;
    localparam int ADDR_W    = 11;

    // Access size encoding; the unused code 2'd3 is handled as a word.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2,
        ST_RSP   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align_extract.sv
// Combinational byte/half/word handling: load extraction with extension, and the
// sub-word store merge that preserves the untouched bytes of the RAM word.
module lsu_align_extract
    import pinwheel_mem_pkg::*;
(
    input  logic [31:0] ld_data,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    output logic [31:0] ld_result,
    input  logic [31:0] st_old,
    input  logic [31:0] st_new,
    input  logic [1:0]  st_size,
    output logic [31:0] st_merged
);

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] s,
                                            input logic sg);
        if (s == SIZE_B)
            return {{24{sg & d[7]}}, d[7:0]};
        else if (s == SIZE_H)
            return {{16{sg & d[15]}}, d[15:0]};
        else
            return d;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [1:0] s);
        if (s == SIZE_B)
            return {old_w[31:8], new_w[7:0]};
        else if (s == SIZE_H)
            return {old_w[31:16], new_w[15:0]};
        else
            return new_w;
    endfunction

    assign ld_result = extract(ld_data, ld_size, ld_signed);
    assign st_merged = merge(st_old, st_new, st_size);

endmodule

// File: rtl/lsu_rmw_2048.sv
// Load/store front end for the 2048-byte rotated-lane data RAM: one request in flight,
// word stores written directly, byte/half stores done as read-modify-write.
module lsu_rmw_2048
    import pinwheel_mem_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_rdata
);

    lsu_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              accept;
    logic              req_is_word;
    logic [DATA_W-1:0] ld_result;
    logic [DATA_W-1:0] st_merged;

    // Handshake: a request transfers in the cycle req_valid & req_ready are both high;
    // the requester holds its fields stable until then, and rsp_valid is never stalled.
    assign req_ready   = (state == ST_IDLE) & reset_n;
    assign accept      = req_valid & req_ready;
    assign req_is_word = req_size[1];

    assign ram_raddr = (state == ST_IDLE) ? req_addr : addr_q;
    assign ram_waddr = ram_raddr;
    assign ram_wdata = (state == ST_MERGE) ? st_merged : req_wdata;
    // Reset gates the write so a MERGE cut short can never touch memory.
    assign ram_wren  = reset_n & ((accept & req_write & req_is_word) | (state == ST_MERGE));

    lsu_align_extract u_align (
        .ld_data   (ram_rdata),
        .ld_size   (size_q),
        .ld_signed (signed_q),
        .ld_result (ld_result),
        .st_old    (ram_rdata),
        .st_new    (wdata_q),
        .st_size   (size_q),
        .st_merged (st_merged)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            signed_q  <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        wdata_q  <= req_wdata;
                        if (!req_write) begin
                            state <= ST_LOAD;
                        end else if (req_is_word) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state <= ST_MERGE;
                        end
                    end
                end
                ST_LOAD: begin
                    state     <= ST_RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= write_q ? '0 : ld_result;
                end
                ST_MERGE: begin
                    state     <= ST_RSP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                end
                ST_RSP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw_2048.sv
// Bench for lsu_rmw_2048: behavioural byte-array RAM, byte-level reference model,
// directed scenarios followed by a streamed and a randomized phase.
module tb_lsu_rmw_2048;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [10:0] ram_raddr;
    logic [10:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0]  ram [2048];
    logic [7:0]  ref_mem [2048];
    logic [31:0] exp_q [$];

    lsu_rmw_2048 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_raddr  (ram_raddr),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_wren   (ram_wren),
        .ram_rdata  (ram_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // RAM: registered read one cycle after the address, write-through on same address.
    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = init_byte(i);
        ram_rdata = '0;
        forever begin
            @(posedge clock);
            if (ram_wren)
                for (int i = 0; i < 4; i++) ram[(int'(ram_waddr) + i) % 2048] = ram_wdata[8*i +: 8];
            ram_rdata <= {ram[(int'(ram_raddr) + 3) % 2048], ram[(int'(ram_raddr) + 2) % 2048],
                          ram[(int'(ram_raddr) + 1) % 2048], ram[int'(ram_raddr)]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [10:0] a, input logic [1:0] sz,
                                               input logic sg);
        int n;
        longint val;
        n = size_bytes(sz);
        val = 0;
        for (int i = 0; i < n; i++) val += longint'(ref_mem[(int'(a) + i) % 2048]) << (8 * i);
        if (sg && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= (longint'(1) << (8 * n));
        return 32'(val);
    endfunction

    task automatic model_store(input logic [10:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < size_bytes(sz); i++) ref_mem[(int'(a) + i) % 2048] = wd[8*i +: 8];
    endtask

    // One isolated request: checks acceptance, response timing/count, write-enable timing and data.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [10:0] a, input logic [31:0] wd, output logic [31:0] got);
        int wait_c, rsp_at, rsp_cnt, wren_cnt, wren_at, exp_rsp_at;
        logic [31:0] exp;
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        #1;
        wait_c = 0;
        while (!req_ready && wait_c < 16) begin
            @(negedge clock); #1; wait_c++;
        end
        check("accept_ready", 32'(req_ready), 32'd1);
        if (w) begin
            model_store(a, sz, wd);
            exp = '0;
            exp_rsp_at = sz[1] ? 1 : 2;
        end else begin
            exp = model_load(a, sz, sg);
            exp_rsp_at = 2;
        end
        rsp_at = -1; rsp_cnt = 0; wren_cnt = 0; wren_at = -1; got = 'x;
        for (int c = 0; c < 5; c++) begin
            if (ram_wren) begin
                wren_cnt++;
                if (wren_at < 0) wren_at = c;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                if (rsp_at < 0) begin
                    rsp_at = c;
                    got = rsp_rdata;
                end
            end
            @(negedge clock);
            if (c == 0) req_valid = 1'b0;
            #1;
        end
        check("rsp_count", 32'(rsp_cnt), 32'd1);
        check("rsp_latency", 32'(rsp_at), 32'(exp_rsp_at));
        check("wren_count", 32'(wren_cnt), 32'(w));
        if (w) check("wren_cycle", 32'(wren_at), sz[1] ? 32'd0 : 32'd1);
        check("rsp_rdata", got, exp);
    endtask

    // Back-to-back requests with req_valid held high; ready and responses checked every cycle.
    task automatic stream_test(input int n_req);
        logic        w_a  [16];
        logic [1:0]  sz_a [16];
        logic        sg_a [16];
        logic [10:0] a_a  [16];
        logic [31:0] wd_a [16];
        int k, c, next_free, rsps, wrens, stores;
        for (int i = 0; i < n_req; i++) begin
            w_a[i] = 1'(i % 2); sz_a[i] = 2'($urandom_range(0, 3)); sg_a[i] = 1'($urandom_range(0, 1));
            a_a[i] = 11'($urandom_range(0, 2047)); wd_a[i] = $urandom;
        end
        k = 0; c = 0; next_free = 0; rsps = 0; wrens = 0; stores = 0;
        exp_q.delete();
        @(negedge clock);
        req_valid = 1'b1; req_write = w_a[0]; req_size = sz_a[0]; req_signed = sg_a[0];
        req_addr = a_a[0]; req_wdata = wd_a[0];
        #1;
        while ((k < n_req || exp_q.size() > 0) && c < 200) begin
            if (rsp_valid) begin
                rsps++;
                check("stream_rsp_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("stream_rdata", rsp_rdata, exp_q.pop_front());
            end
            if (ram_wren) wrens++;
            if (k < n_req) begin
                check("stream_ready", 32'(req_ready), 32'(c >= next_free));
                if (req_ready) begin
                    if (w_a[k]) begin
                        model_store(a_a[k], sz_a[k], wd_a[k]);
                        exp_q.push_back('0);
                        stores++;
                        next_free = c + (sz_a[k][1] ? 2 : 3);
                    end else begin
                        exp_q.push_back(model_load(a_a[k], sz_a[k], sg_a[k]));
                        next_free = c + 3;
                    end
                    k++;
                end
            end
            @(negedge clock);
            if (k < n_req) begin
                req_write = w_a[k]; req_size = sz_a[k]; req_signed = sg_a[k];
                req_addr = a_a[k]; req_wdata = wd_a[k];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            c++;
        end
        check("stream_accepts", 32'(k), 32'(n_req));
        check("stream_rsps", 32'(rsps), 32'(n_req));
        check("stream_wren_cycles", 32'(wrens), 32'(stores));
    endtask

    initial begin
        logic [31:0] got;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);

        // Reset: a word store presented during reset must not write or be accepted.
        reset_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
        req_signed = 1'b0; req_addr = 11'd0; req_wdata = 32'hFFFF_FFFF;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_ram_wren", 32'(ram_wren), 32'd0);
        #20;
        @(negedge clock);
        req_valid = 1'b0;
        reset_n = 1'b1;

        // Word store / load round trip.
        do_req(1'b1, 2'd2, 1'b0, 11'd5, 32'hDEAD_BEEF, got);
        do_req(1'b0, 2'd2, 1'b0, 11'd5, 32'd0, got);
        check("t1_word_load", got, 32'hDEAD_BEEF);

        // Byte store merges into the existing word; signed and unsigned byte loads.
        do_req(1'b1, 2'd0, 1'b1, 11'd6, 32'h1234_5680, got);
        do_req(1'b0, 2'd0, 1'b1, 11'd6, 32'd0, got);
        check("t2_signed_byte", got, 32'hFFFF_FF80);
        do_req(1'b0, 2'd0, 1'b0, 11'd6, 32'd0, got);
        check("t2_unsigned_byte", got, 32'h0000_0080);
        do_req(1'b0, 2'd2, 1'b0, 11'd5, 32'd0, got);
        check("t2_word_after_merge", got, 32'hDEAD_80EF);

        // Half store at the top of memory; word load wraps into bytes 0 and 1.
        do_req(1'b1, 2'd1, 1'b1, 11'd2046, 32'h1234_ABCD, got);
        do_req(1'b0, 2'd2, 1'b0, 11'd2046, 32'd0, got);
        check("t3_wrap_low_half", {16'd0, got[15:0]}, 32'h0000_ABCD);
        do_req(1'b0, 2'd1, 1'b1, 11'd2046, 32'd0, got);
        check("t3_signed_half", got, 32'hFFFF_ABCD);

        // Size 3 behaves as a word store.
        do_req(1'b1, 2'd3, 1'b0, 11'd0, 32'hCAFE_F00D, got);
        do_req(1'b0, 2'd3, 1'b0, 11'd0, 32'd0, got);
        check("t6_size3_word", got, 32'hCAFE_F00D);
        do_req(1'b0, 2'd2, 1'b0, 11'd2046, 32'd0, got);
        check("t6_wrap_word", got, 32'hF00D_ABCD);

        // Continuous requests, alternating loads and stores.
        stream_test(12);

        // Reset during MERGE: no write, no response.
        do_req(1'b1, 2'd0, 1'b0, 11'd10, 32'h0000_0011, got);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 11'd10; req_wdata = 32'h0000_0055;
        #1;
        check("t5_accept_ready", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        check("t5_merge_wren", 32'(ram_wren), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_wren_drop", 32'(ram_wren), 32'd0);
        check("t5_ready_in_reset", 32'(req_ready), 32'd0);
        check("t5_rsp_in_reset", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); #1;
            check("t5_rsp_held_reset", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("t5_rsp_after_reset", 32'(rsp_valid), 32'd0);
            check("t5_wren_after_reset", 32'(ram_wren), 32'd0);
        end
        do_req(1'b0, 2'd2, 1'b0, 11'd8, 32'd0, got);
        check("t5_byte2_kept", {24'd0, got[23:16]}, 32'h0000_0011);

        // Randomized isolated requests against the reference model.
        for (int i = 0; i < 24; i++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   11'($urandom_range(0, 2047)), $urandom, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
